// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: bubble instruction, major opcodes and the fetch FSM encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > stall (hold) > load > bubble.
module if_id_reg #(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        load_en,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid
);
    import riscv_pkg::*;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr    <= BUBBLE_INSTR;
            pc       <= 32'd0;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr <= BUBBLE_INSTR;
            valid <= 1'b0;
        end else if (stall) begin
            instr <= instr;
            valid <= valid;
        end else if (load_en) begin
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc_plus4;
            valid    <= 1'b1;
        end else begin
            // Nothing delivered this cycle: the PC fields are left as they were.
            instr <= BUBBLE_INSTR;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, request/ack memory port, one-entry skid buffer, IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic [6:0]  opcode_d,
    output logic [2:0]  funct3_d,
    output logic [6:0]  funct7_d
);
    import riscv_pkg::*;

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_f, pc_f_nxt, pc_f_plus4;
    logic [31:0]  addr_nxt, skid_instr, skid_nxt, redirect_tgt;
    logic         req_nxt;
    logic         load_en;
    logic [31:0]  load_instr;

    assign redirect_tgt = word_align(redirect_pc);
    assign pc_f_plus4   = pc_f + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_f       <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            skid_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            pc_f       <= pc_f_nxt;
            imem_req   <= req_nxt;
            imem_addr  <= addr_nxt;
            skid_instr <= skid_nxt;
        end
    end

    // pc_f always names the instruction being fetched or held in the skid buffer.
    always_comb begin
        state_nxt  = state;
        pc_f_nxt   = pc_f;
        req_nxt    = imem_req;
        addr_nxt   = imem_addr;
        skid_nxt   = skid_instr;
        load_en    = 1'b0;
        load_instr = skid_instr;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                req_nxt   = 1'b1;
                if (redirect_en) begin
                    pc_f_nxt = redirect_tgt;
                    addr_nxt = redirect_tgt;
                end else begin
                    addr_nxt = pc_f;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_en) begin
                        pc_f_nxt = redirect_tgt;
                        addr_nxt = redirect_tgt;
                    end else if (stall_f) begin
                        skid_nxt  = imem_rdata;
                        req_nxt   = 1'b0;
                        state_nxt = HOLD;
                    end else begin
                        load_en    = 1'b1;
                        load_instr = imem_rdata;
                        pc_f_nxt   = pc_f_plus4;
                        addr_nxt   = pc_f_plus4;
                    end
                end else if (redirect_en) begin
                    // The outstanding request cannot be aborted; wait it out in DRAIN.
                    pc_f_nxt  = redirect_tgt;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_en) begin
                    pc_f_nxt = redirect_tgt;
                end
                if (imem_ack) begin
                    state_nxt = FETCH;
                    addr_nxt  = redirect_en ? redirect_tgt : pc_f;
                end
            end
            HOLD: begin
                if (redirect_en) begin
                    pc_f_nxt  = redirect_tgt;
                    addr_nxt  = redirect_tgt;
                    req_nxt   = 1'b1;
                    state_nxt = FETCH;
                end else if (!stall_f) begin
                    load_en   = 1'b1;
                    pc_f_nxt  = pc_f_plus4;
                    addr_nxt  = pc_f_plus4;
                    req_nxt   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush_d),
        .stall        (stall_f),
        .load_en      (load_en),
        .load_instr   (load_instr),
        .load_pc      (pc_f),
        .load_pc_plus4(pc_f_plus4),
        .instr        (instr_d),
        .pc           (pc_d),
        .pc_plus4     (pc_plus4_d),
        .valid        (valid_d)
    );

    assign opcode_d = instr_d[6:0];
    assign funct3_d = instr_d[14:12];
    assign funct7_d = instr_d[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random-latency memory, stalls and redirects against a PC-stream model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n, stall_f, flush_d, redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack, valid_d;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d;
    logic [6:0]  opcode_d, funct7_d;
    logic [2:0]  funct3_d;

    logic        w_zero, w_req, w_ack, w_valid, w_seen;
    logic [31:0] w_zero32, w_addr, w_rdata, w_instr, w_pc, w_pc4;
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    bit mem_busy, mem_new, mem_acked;
    int mem_cnt, mem_lat, fixed_lat;

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .flush_d(flush_d),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
        .opcode_d(opcode_d), .funct3_d(funct3_d), .funct7_d(funct7_d)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall_f(w_zero), .flush_d(w_zero),
        .redirect_en(w_zero), .redirect_pc(w_zero32),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr_d(w_instr), .pc_d(w_pc), .pc_plus4_d(w_pc4), .valid_d(w_valid),
        .opcode_d(w_op), .funct3_d(w_f3), .funct7_d(w_f7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Expected program order restarts at a new PC after reset or redirect.
    task automatic exp_restart(input logic [31:0] target);
        exp_t e;
        e.pc    = target & 32'hFFFF_FFFC;
        e.instr = mem_f(e.pc);
        exp_q.delete();
        exp_q.push_back(e);
    endtask

    task automatic mem_drive();
        imem_ack  = 1'b0;
        mem_new   = 1'b0;
        mem_acked = 1'b0;
        if (!imem_req) begin
            mem_busy = 1'b0;
        end else begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_new  = 1'b1;
                mem_lat  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            end else begin
                mem_cnt++;
            end
            if (mem_cnt == mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_f(imem_addr);
                mem_busy   = 1'b0;
                mem_acked  = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_drive();
    endtask

    task automatic wait_valid(input int limit, input string name);
        int n = 0;
        while (!valid_d && n < limit) begin
            tick();
            n++;
        end
        chk(name, {31'd0, valid_d}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'd0);
        chk({tag, "_instr"}, instr_d, NOP);
        chk({tag, "_pc"},    pc_d, 32'd0);
        chk({tag, "_pc4"},   pc_plus4_d, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
    endtask

    // Single-cycle-ack responder for the wrap-around instance.
    initial begin
        w_zero = 1'b0; w_zero32 = 32'd0; w_ack = 1'b0; w_rdata = 32'd0; w_seen = 1'b0;
        forever begin
            @(negedge clk);
            w_ack = 1'b0;
            if (w_req) begin
                if (w_seen) begin
                    w_ack   = 1'b1;
                    w_rdata = mem_f(w_addr);
                    w_seen  = 1'b0;
                end else begin
                    w_seen = 1'b1;
                end
            end else begin
                w_seen = 1'b0;
            end
        end
    end

    // Monitor: one look per edge at what IF/ID and the memory port did.
    initial begin
        logic        p_req;
        logic [31:0] p_addr, s_instr, s_pc, s_pc4;
        logic        s_valid;
        exp_t        e;
        p_req = 1'b0; p_addr = 32'd0;
        s_instr = NOP; s_pc = 32'd0; s_pc4 = 32'd0; s_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (flush_d) begin
                    chk("flush_valid", {31'd0, valid_d}, 32'd0);
                    chk("flush_instr", instr_d, NOP);
                end else if (stall_f) begin
                    chk("stall_instr", instr_d, s_instr);
                    chk("stall_pc", pc_d, s_pc);
                    chk("stall_pc4", pc_plus4_d, s_pc4);
                    chk("stall_valid", {31'd0, valid_d}, {31'd0, s_valid});
                end else if (valid_d) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_instr", pc_d, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", pc_d, e.pc);
                        chk("sb_instr", instr_d, e.instr);
                        chk("sb_pc4", pc_plus4_d, e.pc + 32'd4);
                        chk("sb_fields", {15'd0, funct7_d, funct3_d, opcode_d},
                            {15'd0, e.instr[31:25], e.instr[14:12], e.instr[6:0]});
                        e.pc    = e.pc + 32'd4;
                        e.instr = mem_f(e.pc);
                        exp_q.push_back(e);
                    end
                end else begin
                    chk("bubble_instr", instr_d, NOP);
                end
                if (p_req && !imem_ack) begin
                    chk("req_held", {31'd0, imem_req}, 32'd1);
                    chk("addr_held", imem_addr, p_addr);
                end
                chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            end
            p_req = imem_req; p_addr = imem_addr;
            s_instr = instr_d; s_pc = pc_d; s_pc4 = pc_plus4_d; s_valid = valid_d;
        end
    end

    // Stimulus: directed scenarios, a random phase, then reset during a drain.
    initial begin
        int    n, stall_left;
        logic [31:0] old_addr;
        rst_n = 1'b0; stall_f = 1'b0; flush_d = 1'b0; redirect_en = 1'b0; redirect_pc = 32'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0; fixed_lat = 1;
        mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; stall_left = 0;

        repeat (3) tick();
        chk_reset_outputs("rst");
        exp_restart(32'h0);
        rst_n = 1'b1;

        wait_valid(20, "first_valid_timeout");
        chk("first_instr", instr_d, 32'h0050_0093);
        chk("first_opcode", {25'd0, opcode_d}, 32'h13);
        chk("first_pc4", pc_plus4_d, 32'd4);
        chk("first_next_addr", imem_addr, 32'd4);
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'd0);
        chk("wrap_next_addr", w_addr, 32'd0);

        n = 0;
        while (!mem_acked && n < 20) begin tick(); n++; end
        chk("stall_ack_timeout", {31'd0, mem_acked}, 32'd1);
        stall_f = 1'b1;
        repeat (3) begin
            tick();
            chk("hold_req_low", {31'd0, imem_req}, 32'd0);
        end
        tick();
        stall_f = 1'b0;

        n = 0;
        while (!mem_acked && n < 20) begin tick(); n++; end
        chk("redir_ack_timeout", {31'd0, mem_acked}, 32'd1);
        redirect_en = 1'b1; redirect_pc = 32'h200; flush_d = 1'b1;
        exp_restart(32'h200);
        tick();
        redirect_en = 1'b0; flush_d = 1'b0;
        chk("redir_ack_bubble", {31'd0, valid_d}, 32'd0);
        chk("redir_ack_addr", imem_addr, 32'h200);

        fixed_lat = 3;
        n = 0;
        while (!mem_new && n < 20) begin tick(); n++; end
        chk("drain_start_timeout", {31'd0, mem_new}, 32'd1);
        old_addr = imem_addr;
        redirect_en = 1'b1; redirect_pc = 32'h101;
        exp_restart(32'h101);
        tick();
        redirect_en = 1'b0;
        chk("drain_addr_kept", imem_addr, old_addr);
        wait_valid(20, "drain_valid_timeout");
        chk("drain_target_pc", pc_d, 32'h100);

        fixed_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (stall_left > 0) stall_left--;
            else if ($urandom_range(0, 9) == 0) stall_left = $urandom_range(1, 5);
            stall_f     = (stall_left > 0);
            redirect_en = 1'b0;
            flush_d     = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                redirect_en = 1'b1;
                redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | $urandom_range(0, 3))
                                                          : ($urandom() & 32'h0000_FFFF);
                flush_d     = 1'($urandom_range(0, 1));
                exp_restart(redirect_pc);
            end
        end
        tick();
        stall_f = 1'b0; redirect_en = 1'b0; flush_d = 1'b0;

        fixed_lat = 4;
        n = 0;
        while (!mem_new && n < 50) begin tick(); n++; end
        chk("rstdrain_start_timeout", {31'd0, mem_new}, 32'd1);
        redirect_en = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("rstdrain");
        exp_restart(32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("late_ack_ignored", {31'd0, valid_d}, 32'd0);
        fixed_lat = 1;
        wait_valid(20, "after_reset_timeout");
        chk("after_reset_pc", pc_d, 32'd0);
        chk("after_reset_instr", instr_d, 32'h0050_0093);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Pipelined RV32I instruction-fetch stage and IF/ID pipeline register; producer of the instruction fields consumed by the ID-stage decoder (opcode, funct3, funct7).
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Supports variable memory latency, stall, flush and branch/jump redirect.
- Sits between the instruction memory and the ID stage; redirects come from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- stall_f  input  1  hazard unit: hold IF/ID and PC
- flush_d  input  1  squash IF/ID contents to a bubble
- redirect_en  input  1  taken branch/jump from EX
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0
- imem_req  output  1  instruction-memory request
- imem_addr  output  32  request address, word aligned
- imem_ack  input  1  response strobe; imem_rdata is valid in the same cycle
- imem_rdata  input  32  fetched instruction
- instr_d  output  32  IF/ID instruction
- pc_d  output  32  IF/ID PC
- pc_plus4_d  output  32  IF/ID PC+4
- valid_d  output  1  IF/ID holds a real instruction
- opcode_d  output  7  instr_d[6:0]
- funct3_d  output  3  instr_d[14:12]
- funct7_d  output  7  instr_d[31:25]

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc_f=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0.
  - Skid buffer is empty; state=IDLE.
  - Reset mid-transaction abandons it; a late imem_ack after reset is ignored.
- Memory protocol:
  - imem_req and imem_addr are registered and stay stable until the imem_ack cycle.
  - imem_ack never arrives in the cycle imem_req first rises.
  - A request cannot be aborted.
- FSM states:
  - IDLE: left one cycle after reset release; goes to FETCH with imem_req=1, imem_addr=pc_f.
  - FETCH: imem_req=1.
    - On ack, no redirect, stall_f=0: IF/ID loads {imem_rdata, pc, pc+4, valid=1}; pc_f+=4; a new request issues next cycle.
    - On ack with stall_f=1: instruction goes to the skid buffer; go to HOLD with imem_req=0.
    - No ack, redirect_en=1: pc_f<=redirect_pc; go to DRAIN.
  - DRAIN: keeps the old address until ack, then discards the response (IF/ID gets a bubble unless stalled) and issues a request at pc_f (FETCH). A further redirect in DRAIN overwrites pc_f.
  - HOLD: imem_req=0.
    - When stall_f=0: skid buffer moves into IF/ID; go to FETCH at pc_f+4.
    - redirect_en in HOLD: drop the buffer, pc_f<=redirect_pc, go to FETCH.
- Redirect coinciding with ack in FETCH: response discarded; pc_f<=redirect_pc; next request uses the target.
- IF/ID update priority: rst_n > flush_d (bubble) > stall_f (hold) > new instruction > bubble (no instruction delivered, not stalled).
- flush_d and stall_f together: flush wins.
- Throughput: one instruction per 2 cycles with 1-cycle-ack memory.
- Latency: address to IF/ID = ack latency + 1 edge.
- Arithmetic: pc+4 is 32-bit, modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Field outputs are combinational slices of the instr_d register.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR, opcode constants (OP_LUI, OP_JAL, OP_BRANCH, ...).
  - fetch FSM state encoding: IDLE, FETCH, DRAIN, HOLD.
- One sub-module if_id_reg: the IF/ID register with flush/stall priority and bubble insertion. The FSM and PC stay in fetch_unit.

Test Plan:
- Reset, then release, 1-cycle-ack memory returning 32'h00500093 at addr 0:
  - imem_addr=0; instr_d=32'h00500093, opcode_d=7'h13, pc_d=0, pc_plus4_d=4, valid_d=1.
  - Next imem_addr=4.
- Ack delayed 3 cycles: imem_addr stays 0x8 throughout; IF/ID shows bubbles (valid_d=0, instr_d=NOP) until the edge after ack.
- stall_f=1 for 4 cycles, ack arriving during the stall:
  - IF/ID unchanged while stalled; imem_req=0 in HOLD.
  - After release, IF/ID shows the held instruction and the next request is at pc+4. No instruction lost or duplicated.
- redirect_en=1, redirect_pc=0x100, while a request to 0x10 is outstanding (DRAIN):
  - 0x10 response discarded; next request is 0x100; pc_d=0x100 appears with valid_d=1.
- Redirect to 0x200 in the same cycle as ack, with flush_d=1: IF/ID becomes a bubble; next imem_addr=0x200.
- RESET_PC=32'hFFFF_FFFC: after the first fetch, pc_plus4_d=0 and the next imem_addr=0.
- rst_n=0 mid-DRAIN: all outputs return to reset values; a late imem_ack is ignored.
